train_dispatch_checker: RTL and testbench
=========================================

Name: train_dispatch_checker

Overview:
- Parametrised departure-order checker for a dead-end station (LIFO siding).
- Trains numbered 1..K arrive in ascending order. The block streams a requested departure order one beat at a time and decides whether the station can realise it.
- Generalised over train count and station capacity. Adds in_ready backpressure, a per-beat handshake, first-failure index and peak-occupancy reporting.
- Sits between the schedule loader and the dispatch controller.

Parameters:
- MAX_N, 16: maximum trains per run.
- CAP, 16: station capacity, i.e. maximum trains parked at once (1..MAX_N).
- W, $clog2(MAX_N+1): width of train number, occupancy and beat-index fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  departure beat valid
- in_ready  out  1  block can accept a beat
- in_last  in  1  final beat of the run; qualified by in_valid
- data  in  W  requested departing train number
- out_valid  out  1  one-cycle verdict strobe
- result  out  1  1 = order feasible
- fail_idx  out  W+1  1-based index of the first failing beat; 0 on pass
- peak_occ  out  W  maximum station occupancy reached in the run

Behaviour:
- Reset: all outputs 0 except in_ready = 1. FSM goes to S_IDLE; stack emptied; next_in = 1; beat_cnt = 0. Reset mid-run discards the run and produces no out_valid.
- A transfer occurs when in_valid && in_ready. Beats in S_IDLE start a run; S_IDLE behaves as S_RUN for the first beat.
- in_ready = 1 in S_IDLE, S_RUN and S_DRAIN; 0 in S_PUSH and S_OUT.
- beat_cnt increments on each transfer and saturates at 2^(W+1)-1.
- Processing an accepted beat d, first matching rule wins:
  - d == 0, d > MAX_N, or beat_cnt > MAX_N: fail.
  - d == next_in: depart immediately; next_in <= d+1; stay in S_RUN.
  - d > next_in: go to S_PUSH.
  - d < next_in, stack non-empty, top == d: pop.
  - d < next_in, any other case: fail. This covers duplicates.
- S_PUSH: push next_in and increment next_in, one train per cycle, until next_in == d. Then depart d (next_in <= d+1) in the same cycle and return to S_RUN, or go to S_OUT if the beat carried in_last.
- Overflow: a push attempted with occupancy == CAP fails the run. The train departing this beat never occupies the station.
- peak_occ updates after every push.
- Fail handling:
  - Record fail_idx = beat_cnt of the failing beat; result = 0.
  - Enter S_DRAIN, or S_OUT if that beat had in_last.
  - S_DRAIN accepts and discards beats until in_last, then goes to S_OUT.
  - Only the first failure is recorded.
- End check, after the in_last beat is processed without failure: pass iff the stack is empty and next_in-1 == beat_cnt. Otherwise fail with fail_idx = beat_cnt.
- S_OUT lasts exactly 1 cycle:
  - out_valid = 1; result, fail_idx and peak_occ are valid.
  - Next state is S_IDLE, where run state is cleared.
  - Outputs other than in_ready are 0 whenever out_valid = 0.
- Latency: S_OUT is the cycle after the in_last beat completes. That is one cycle after acceptance, or one cycle after the final push cycle.

Decomposition:
- Package train_pkg holds:
  - FSM state enum: S_IDLE, S_RUN, S_PUSH, S_DRAIN, S_OUT.
  - Width helper function.
  - Verdict struct {result, fail_idx, peak_occ}.
- One sub-module, train_lifo: depth CAP, width W, with push, pop, top, empty, full and count.

Test Plan:
- MAX_N=10, CAP=10; beats 3,2,1 (last on 1) -> in_ready low 2 cycles after beat 1; out_valid result=1, fail_idx=0, peak_occ=2.
- Beats 3,1,2 -> result=0, fail_idx=2, peak_occ=2; beat 3 (2) is accepted while in S_DRAIN.
- CAP=2; beats 4,3,2,1 -> overflow on the third push: result=0, fail_idx=1, peak_occ=2; remaining beats drained.
- Beats 1,1 (last) -> result=0, fail_idx=2. Beats 1,3 (last) -> end check fails, fail_idx=2.
- Single beat 1 with in_last -> out_valid on the next cycle, result=1, peak_occ=0. Back-to-back runs produce independent verdicts.
- Assert rst_n while in S_PUSH during beat 5 -> all outputs 0, in_ready=1, no out_valid. A fresh run 2,1 then yields result=1.

Source files
------------

// File: rtl/train_pkg.sv
// Shared types and helpers for the dead-end station departure-order checker.
package train_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PUSH  = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_e;

   // Verdict fields are sized for the largest supported run; the top slices them.
   localparam int VW = 8;

   typedef struct packed {
      logic          result;
      logic [VW-1:0] fail_idx;
      logic [VW-1:0] peak_occ;
   } verdict_t;

   // Bits needed to hold the values 0..n
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < (n + 1)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/train_dispatch_checker_lifo.sv
// The siding itself: a CAP-deep LIFO of parked train numbers.
// Entry 0 is always the top, so neither port needs an address decoder.
module train_lifo #(
   parameter int CAP = 16,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o,
   output logic [W-1:0] count_o
);

   logic [W-1:0] mem_q [CAP];
   logic [W-1:0] cnt_q;

   assign top_o   = mem_q[0];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == W'(CAP));
   assign count_o = cnt_q;

   // Shift-register stack: push shifts down, pop shifts up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         for (int i = 0; i < CAP; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (push_i && !full_o) begin
         cnt_q    <= cnt_q + W'(1);
         mem_q[0] <= din_i;
         for (int i = 1; i < CAP; i++) mem_q[i] <= mem_q[i-1];
      end else if (pop_i && !empty_o) begin
         cnt_q <= cnt_q - W'(1);
         for (int i = 0; i < CAP - 1; i++) mem_q[i] <= mem_q[i+1];
         mem_q[CAP-1] <= '0;
      end else begin
         cnt_q <= cnt_q;
      end
   end

endmodule

// File: rtl/train_dispatch_checker.sv
// Departure-order checker for a dead-end (LIFO) siding: streams a requested order
// and reports feasibility, the first failing beat and the peak station occupancy.
module train_dispatch_checker
   import train_pkg::*;
#(
   parameter int MAX_N = 16,
   parameter int CAP   = 16,
   parameter int W     = idx_width(MAX_N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic         in_last_i,
   input  logic [W-1:0] data_i,
   output logic         out_valid_o,
   output logic         result_o,
   output logic [W:0]   fail_idx_o,
   output logic [W-1:0] peak_occ_o
);

   localparam int CW = W + 1;
   localparam logic [CW-1:0] MAXN_C = CW'(MAX_N);

   state_e        state_q, state_d;
   logic [CW-1:0] next_in_q, next_in_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] fidx_q, fidx_d;
   logic [W-1:0]  tgt_q, tgt_d;
   logic [W-1:0]  peak_q, peak_d;
   logic          last_q, last_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   verdict_t      out_q, out_d;

   logic          xfer_s, push_s, pop_s, clr_s;
   logic          empty_s, full_s;
   logic [W-1:0]  top_s, occ_s;
   logic [CW-1:0] cnt_inc_s, d_ext_s, tgt_ext_s;
   logic          unused_s;

   train_lifo #(.CAP(CAP), .W(W)) u_lifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr_s),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .din_i   (next_in_q[W-1:0]),
      .top_o   (top_s),
      .empty_o (empty_s),
      .full_o  (full_s),
      .count_o (occ_s)
   );

   assign xfer_s    = in_valid_i && in_ready_q;
   assign cnt_inc_s = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
   assign d_ext_s   = CW'(data_i);
   assign tgt_ext_s = CW'(tgt_q);

   // Next state, run bookkeeping and verdict capture
   always_comb begin
      state_d   = state_q;
      next_in_d = next_in_q;
      cnt_d     = cnt_q;
      fidx_d    = fidx_q;
      tgt_d     = tgt_q;
      peak_d    = peak_q;
      last_d    = last_q;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      clr_s     = 1'b0;
      out_d     = '0;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (xfer_s) begin
               cnt_d = cnt_inc_s;
               if (data_i == '0 || d_ext_s > MAXN_C || cnt_inc_s > MAXN_C) begin
                  fidx_d  = cnt_inc_s;
                  state_d = in_last_i ? S_OUT : S_DRAIN;
               end else if (d_ext_s == next_in_q) begin
                  next_in_d = d_ext_s + CW'(1);
                  if (in_last_i) begin
                     fidx_d  = (empty_s && d_ext_s == cnt_inc_s) ? '0 : cnt_inc_s;
                     state_d = S_OUT;
                  end else begin
                     state_d = S_RUN;
                  end
               end else if (d_ext_s > next_in_q) begin
                  tgt_d   = data_i;
                  last_d  = in_last_i;
                  state_d = S_PUSH;
               end else if (!empty_s && top_s == data_i) begin
                  pop_s = 1'b1;
                  if (in_last_i) begin
                     // the pop empties the siding exactly when one train is parked
                     fidx_d  = (occ_s == W'(1) && next_in_q - CW'(1) == cnt_inc_s) ? '0 : cnt_inc_s;
                     state_d = S_OUT;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  fidx_d  = cnt_inc_s;
                  state_d = in_last_i ? S_OUT : S_DRAIN;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_PUSH: begin
            if (full_s) begin
               fidx_d  = cnt_q;
               state_d = last_q ? S_OUT : S_DRAIN;
            end else begin
               push_s    = 1'b1;
               next_in_d = next_in_q + CW'(1);
               peak_d    = (occ_s >= peak_q) ? occ_s + W'(1) : peak_q;
               if (next_in_q + CW'(1) == tgt_ext_s) begin
                  next_in_d = tgt_ext_s + CW'(1);
                  if (last_q) begin
                     // a train was just parked, so the siding cannot end empty
                     fidx_d  = cnt_q;
                     state_d = S_OUT;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  state_d = S_PUSH;
               end
            end
         end
         S_DRAIN: begin
            if (xfer_s) begin
               cnt_d   = cnt_inc_s;
               state_d = in_last_i ? S_OUT : S_DRAIN;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_OUT: begin
            state_d   = S_IDLE;
            next_in_d = CW'(1);
            cnt_d     = '0;
            fidx_d    = '0;
            tgt_d     = '0;
            peak_d    = '0;
            last_d    = 1'b0;
            clr_s     = 1'b1;
         end
         default: begin
            state_d   = S_IDLE;
            next_in_d = CW'(1);
            cnt_d     = '0;
            fidx_d    = '0;
            tgt_d     = '0;
            peak_d    = '0;
            last_d    = 1'b0;
            clr_s     = 1'b1;
         end
      endcase
      in_ready_d  = (state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_DRAIN);
      out_valid_d = (state_d == S_OUT);
      if (out_valid_d) begin
         out_d.result   = (fidx_d == '0);
         out_d.fail_idx = VW'(fidx_d);
         out_d.peak_occ = VW'(peak_d);
      end else begin
         out_d = '0;
      end
   end

   // State, run and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         next_in_q   <= CW'(1);
         cnt_q       <= '0;
         fidx_q      <= '0;
         tgt_q       <= '0;
         peak_q      <= '0;
         last_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         next_in_q   <= next_in_d;
         cnt_q       <= cnt_d;
         fidx_q      <= fidx_d;
         tgt_q       <= tgt_d;
         peak_q      <= peak_d;
         last_q      <= last_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = out_q.result;
   assign fail_idx_o  = out_q.fail_idx[CW-1:0];
   assign peak_occ_o  = out_q.peak_occ[W-1:0];
   assign unused_s    = ^{out_q.fail_idx >> CW, out_q.peak_occ >> W};

endmodule

// File: tb/tb_train_dispatch_checker.sv
// Bench for train_dispatch_checker: two instances (roomy and tight siding) checked
// every cycle against a queue-based model of the LIFO station.
module tb_train_dispatch_checker;

   localparam int MAXN  = 10;
   localparam int CAP_A = 10;
   localparam int CAP_B = 2;
   localparam int WB    = 4;

   typedef struct {
      int res;
      int fidx;
      int peak;
      int cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sel = 1'b0;
   logic          drv_valid = 1'b0;
   logic          drv_last = 1'b0;
   logic [WB-1:0] drv_data = '0;
   logic          vld_a, vld_b, rdy_a, rdy_b, ov_a, ov_b, res_a, res_b;
   logic [WB:0]   fi_a, fi_b;
   logic [WB-1:0] pk_a, pk_b;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   assign vld_a = drv_valid && !sel;
   assign vld_b = drv_valid && sel;

   train_dispatch_checker #(.MAX_N(MAXN), .CAP(CAP_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid_i(vld_a), .in_ready_o(rdy_a), .in_last_i(drv_last),
      .data_i(drv_data), .out_valid_o(ov_a), .result_o(res_a), .fail_idx_o(fi_a), .peak_occ_o(pk_a));

   train_dispatch_checker #(.MAX_N(MAXN), .CAP(CAP_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid_i(vld_b), .in_ready_o(rdy_b), .in_last_i(drv_last),
      .data_i(drv_data), .out_valid_o(ov_b), .result_o(res_b), .fail_idx_o(fi_b), .peak_occ_o(pk_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, req, $time);
      end
   endtask

   // Station model: stack of parked trains, next arriving train, first failing beat.
   // st[i] = cycles the block spends parking trains after accepting beat i.
   function automatic void model(input int b[$], input int cap, output exp_t v, output int st[$]);
      int stk[$];
      int nxt, fail, peak;
      nxt = 1; fail = 0; peak = 0;
      st = {};
      foreach (b[i]) begin
         int d, k;
         d = b[i]; k = 0;
         if (fail == 0) begin
            if (d < 1 || d > MAXN || i + 1 > MAXN) begin
               fail = i + 1;
            end else if (d >= nxt) begin
               if (stk.size() + (d - nxt) > cap) begin
                  k = cap - stk.size() + 1;
                  fail = i + 1;
                  if (cap > peak) peak = cap;
               end else begin
                  k = d - nxt;
                  for (int t = nxt; t < d; t++) stk.push_back(t);
                  if (stk.size() > peak) peak = stk.size();
                  nxt = d + 1;
               end
            end else if (stk.size() > 0 && stk[$] == d) begin
               void'(stk.pop_back());
            end else begin
               fail = i + 1;
            end
         end
         st.push_back(k);
      end
      if (fail == 0 && (stk.size() != 0 || nxt - 1 != b.size())) fail = b.size();
      v.res = (fail == 0) ? 1 : 0;
      v.fidx = fail;
      v.peak = peak;
      v.cyc = 0;
   endfunction

   task automatic cmp(input int k, input logic ov, input logic r, input logic [WB:0] fi,
                      input logic [WB-1:0] pk);
      exp_t e;
      if (ov) begin
         if ((k == 0 && sb_a.size() == 0) || (k == 1 && sb_b.size() == 0)) begin
            chk($sformatf("dut%0d_unexpected_out_valid", k), int'(ov), 0);
         end else begin
            if (k == 0) e = sb_a.pop_front();
            else e = sb_b.pop_front();
            chk($sformatf("dut%0d_verdict_cycle", k), cyc, e.cyc);
            chk($sformatf("dut%0d_result", k), int'(r), e.res);
            chk($sformatf("dut%0d_fail_idx", k), int'(fi), e.fidx);
            chk($sformatf("dut%0d_peak_occ", k), int'(pk), e.peak);
         end
      end else begin
         chk($sformatf("dut%0d_outputs_zero", k), int'({r, fi, pk}), 0);
      end
   endtask

   // Per-cycle output comparison against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         cmp(0, ov_a, res_a, fi_a, pk_a);
         cmp(1, ov_b, res_b, fi_b, pk_b);
      end
   end

   function automatic logic cur_rdy();
      return sel ? rdy_b : rdy_a;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cur_rdy() && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", int'(cur_rdy()), 1);
   endtask

   task automatic run(input logic s, input int b[$], input int er, input int ef, input int ep);
      exp_t e;
      int   st[$];
      int   n;
      model(b, s ? CAP_B : CAP_A, e, st);
      chk("model_result_lit", e.res, er);
      chk("model_fail_idx_lit", e.fidx, ef);
      chk("model_peak_lit", e.peak, ep);
      sel = s;
      foreach (b[i]) begin
         wait_ready();
         drv_valid = 1'b1;
         drv_data  = WB'(b[i]);
         drv_last  = (i == b.size() - 1);
         if (drv_last) begin
            e.cyc = cyc + st[i] + 1;
            if (s) sb_b.push_back(e);
            else sb_a.push_back(e);
         end
         @(negedge clk);
         drv_valid = 1'b0;
         drv_last  = 1'b0;
         drv_data  = '0;
         if (i != b.size() - 1) begin
            n = 0;
            while (!cur_rdy() && n < 50) begin
               @(negedge clk);
               n++;
            end
            chk("stall_cycles", n, st[i]);
         end
      end
   endtask

   task automatic drain_sb();
      int n;
      n = 0;
      while ((sb_a.size() + sb_b.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("verdict_timeout", sb_a.size() + sb_b.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   q[$];
      int   st[$];
      exp_t v;

      repeat (3) @(negedge clk);
      chk("reset_ready_a", int'(rdy_a), 1);
      chk("reset_ready_b", int'(rdy_b), 1);
      chk("reset_out_a", int'({ov_a, res_a, fi_a, pk_a}), 0);
      chk("reset_out_b", int'({ov_b, res_b, fi_b, pk_b}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      q = {3, 2, 1};
      model(q, CAP_A, v, st);
      chk("model_stall_lit", st[0], 2);
      run(1'b0, q, 1, 0, 2);
      q = {3, 1, 2};          run(1'b0, q, 0, 2, 2);
      q = {4, 3, 2, 1};       run(1'b1, q, 0, 1, 2);
      q = {3, 2, 1};          run(1'b1, q, 1, 0, 2);
      q = {1, 1};             run(1'b0, q, 0, 2, 0);
      q = {1, 3};             run(1'b0, q, 0, 2, 1);
      q = {1};                run(1'b0, q, 1, 0, 0);
      q = {1};                run(1'b0, q, 1, 0, 0);
      q = {2, 1};             run(1'b0, q, 1, 0, 1);
      q = {0};                run(1'b0, q, 0, 1, 0);
      q = {11, 1};            run(1'b0, q, 0, 1, 0);
      q = {2, 3, 1};          run(1'b0, q, 1, 0, 1);
      q = {2, 1, 2};          run(1'b0, q, 0, 3, 1);
      q = {2, 1};             run(1'b1, q, 1, 0, 1);
      q = {};
      for (int i = 1; i <= 10; i++) q.push_back(i);
      q.push_back(1);
      run(1'b0, q, 0, 11, 0);
      q = {};
      for (int i = 10; i >= 1; i--) q.push_back(i);
      run(1'b0, q, 1, 0, 9);
      drain_sb();

      // Reset while the fifth beat is still parking trains
      q = {1, 2, 3, 4, 9};
      sel = 1'b0;
      foreach (q[i]) begin
         wait_ready();
         drv_valid = 1'b1;
         drv_data  = WB'(q[i]);
         @(negedge clk);
         drv_valid = 1'b0;
         drv_data  = '0;
      end
      chk("push_ready_low", int'(rdy_a), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_reset_ready", int'(rdy_a), 1);
      chk("midrun_reset_outputs", int'({ov_a, res_a, fi_a, pk_a}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      q = {2, 1};             run(1'b0, q, 1, 0, 1);
      drain_sb();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
